// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF sequencer.
package ro_puf_pkg;

  localparam int unsigned COUNT_W = 12;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned NUM_RO  = 16;

  localparam int unsigned DEF_NBITS  = 16;
  localparam int unsigned DEF_WINDOW = 4095;
  localparam int unsigned DEF_SETTLE = 4;
  localparam int unsigned DEF_OFFSET = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_MEASURE,
    ST_HOLD,
    ST_COMPARE,
    ST_FINISH
  } state_t;

  // Partner RO index; the 4-bit add wraps naturally modulo NUM_RO.
  function automatic logic [SEL_W-1:0] pair_sel(input logic [SEL_W-1:0] k,
                                                input int unsigned       off);
    return k + off[SEL_W-1:0];
  endfunction

endpackage

// File: rtl/ro_puf_sequencer_if.sv
// Request/RO-mux/response bundle between the PUF sequencer and its environment.
interface ro_puf_sequencer_if;
  import ro_puf_pkg::*;

  logic               start;
  logic [COUNT_W-1:0] count1;
  logic [COUNT_W-1:0] count2;
  logic [SEL_W-1:0]   select1;
  logic [SEL_W-1:0]   select2;
  logic               ro_enable;
  logic               cnt_clear;
  logic               busy;
  logic               done;
  logic [NUM_RO-1:0]  response;

  modport master (
    output start, count1, count2,
    input  select1, select2, ro_enable, cnt_clear, busy, done, response
  );

  modport slave (
    input  start, count1, count2,
    output select1, select2, ro_enable, cnt_clear, busy, done, response
  );

endinterface

// File: rtl/ro_puf_timer.sv
// Loadable 12-bit down-counter with zero flag; reused for settle and window intervals.
module ro_puf_timer
  import ro_puf_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_load,
  input  logic [COUNT_W-1:0] i_value,
  output logic               o_zero
);

  logic [COUNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ro_puf_sequencer.sv
// Sequences per-bit RO pair measurements (clear, measure, hold, compare) into a PUF response.
module ro_puf_sequencer
  import ro_puf_pkg::*;
#(
  parameter int unsigned NBITS  = DEF_NBITS,
  parameter int unsigned WINDOW = DEF_WINDOW,
  parameter int unsigned SETTLE = DEF_SETTLE,
  parameter int unsigned OFFSET = DEF_OFFSET
) (
  input  logic               clock,
  input  logic               reset_n,
  ro_puf_sequencer_if.slave  bus
);

  // Timer is loaded with N-1 so that the phase spans exactly N cycles.
  localparam logic [COUNT_W-1:0] SETTLE_M1 = COUNT_W'(SETTLE - 1);
  localparam logic [COUNT_W-1:0] WINDOW_M1 = COUNT_W'(WINDOW - 1);
  localparam logic [SEL_W-1:0]   LAST_K    = SEL_W'(NBITS - 1);

  state_t             r_state;
  logic [SEL_W-1:0]   r_k;
  logic [SEL_W-1:0]   r_sel1;
  logic [SEL_W-1:0]   r_sel2;
  logic               r_en;
  logic               r_clr;
  logic               r_busy;
  logic               r_done;
  logic [NUM_RO-1:0]  r_resp;

  logic               w_load;
  logic [COUNT_W-1:0] w_load_val;
  logic               w_zero;
  logic [SEL_W-1:0]   w_k_next;

  assign w_k_next = r_k + 1'b1;

  ro_puf_timer u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_zero  (w_zero)
  );

  // Timer loads coincide with every transition into a timed phase.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_load     = 1'b1;
          w_load_val = SETTLE_M1;
        end
      end
      ST_CLEAR: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = WINDOW_M1;
        end
      end
      ST_MEASURE: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = SETTLE_M1;
        end
      end
      ST_COMPARE: begin
        if (r_k != LAST_K) begin
          w_load     = 1'b1;
          w_load_val = SETTLE_M1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_sel1  <= '0;
      r_sel2  <= '0;
      r_en    <= 1'b0;
      r_clr   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_resp  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_CLEAR;
            r_k     <= '0;
            r_resp  <= '0;
            r_busy  <= 1'b1;
            r_clr   <= 1'b1;
            r_en    <= 1'b0;
            r_sel1  <= '0;
            r_sel2  <= pair_sel('0, OFFSET);
          end
        end
        ST_CLEAR: begin
          if (w_zero) begin
            r_state <= ST_MEASURE;
            r_clr   <= 1'b0;
            r_en    <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (w_zero) begin
            r_state <= ST_HOLD;
            r_en    <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (w_zero) begin
            r_state <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          r_resp[r_k] <= (bus.count1 >= bus.count2);
          r_clr       <= 1'b1;
          if (r_k == LAST_K) begin
            r_state <= ST_FINISH;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_CLEAR;
            r_k     <= w_k_next;
            r_sel1  <= w_k_next;
            r_sel2  <= pair_sel(w_k_next, OFFSET);
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.select1   = r_sel1;
  assign bus.select2   = r_sel2;
  assign bus.ro_enable = r_en;
  assign bus.cnt_clear = r_clr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.response  = r_resp;

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Randomized self-checking bench for ro_puf_sequencer against a table-based response model.
module tb_ro_puf_sequencer;

  localparam int A_NB = 16, A_W = 16, A_S = 2, A_OFF = 1;
  localparam int B_NB = 4,  B_W = 7,  B_S = 3, B_OFF = 1;
  localparam int A_LEN = A_NB * (2 * A_S + A_W + 1) + 1;
  localparam int B_LEN = B_NB * (2 * B_S + B_W + 1) + 1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ro_puf_sequencer_if ifa ();
  ro_puf_sequencer_if ifb ();

  ro_puf_sequencer #(.NBITS(A_NB), .WINDOW(A_W), .SETTLE(A_S), .OFFSET(A_OFF)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(ifa));
  ro_puf_sequencer #(.NBITS(B_NB), .WINDOW(B_W), .SETTLE(B_S), .OFFSET(B_OFF)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(ifb));

  logic [11:0] tbl [16];
  bit          use_tbl = 1'b0;
  logic [11:0] c1 = 12'd0, c2 = 12'd0;

  assign ifa.count1 = use_tbl ? tbl[ifa.select1] : c1;
  assign ifa.count2 = use_tbl ? tbl[ifa.select2] : c2;
  assign ifb.count1 = c1;
  assign ifb.count2 = c2;

  int total = 0;
  int bad   = 0;

  int          done_a = 0;
  bit          prev_en_a = 1'b0;
  int          len_a = 0;
  logic [7:0]  pairs_a [$];
  int          runs_a [$];

  // Observes DUT A: done pulses, select pair at each window start, window lengths.
  always @(negedge clock) begin
    if (ifa.done === 1'b1) done_a++;
    if (ifa.ro_enable && !prev_en_a) begin
      pairs_a.push_back({ifa.select1, ifa.select2});
      len_a = 1;
    end else if (ifa.ro_enable) begin
      len_a++;
    end else if (prev_en_a) begin
      runs_a.push_back(len_a);
    end
    prev_en_a = ifa.ro_enable;
  end

  task automatic run_a(input bit pulse_meas, input bit pulse_fin,
                       output int cyc, output bit busy_ok, output bit to,
                       output logic [15:0] resp);
    bit pm = 1'b0;
    busy_ok = 1'b1;
    to      = 1'b0;
    cyc     = 0;
    pairs_a.delete();
    runs_a.delete();
    @(negedge clock);
    ifa.start = 1'b1;
    forever begin
      @(negedge clock);
      cyc++;
      ifa.start = 1'b0;
      if (ifa.done === 1'b1) break;
      if (ifa.busy !== 1'b1) busy_ok = 1'b0;
      if (cyc > 3000) begin
        to = 1'b1;
        break;
      end
      if (pulse_meas && !pm && ifa.ro_enable && pairs_a.size() == 3) begin
        ifa.start = 1'b1;
        pm = 1'b1;
      end
    end
    resp = ifa.response;
    if (pulse_fin) ifa.start = 1'b1;
    @(negedge clock);
    ifa.start = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (ifa.select1 !== 4'd0 || ifa.select2 !== 4'd0) begin bad++;
      $display("FAIL reset_sel got=%0d/%0d want=0/0", ifa.select1, ifa.select2); end
    total++; if (ifa.ro_enable !== 1'b0 || ifa.cnt_clear !== 1'b1) begin bad++;
      $display("FAIL reset_en_clr got=%b/%b want=0/1", ifa.ro_enable, ifa.cnt_clear); end
    total++; if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin bad++;
      $display("FAIL reset_busy_done got=%b/%b want=0/0", ifa.busy, ifa.done); end
    total++; if (ifa.response !== 16'h0000) begin bad++;
      $display("FAIL reset_resp got=%h want=0000", ifa.response); end
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    total++; if (ifa.cnt_clear !== 1'b1 || ifa.ro_enable !== 1'b0 || ifb.cnt_clear !== 1'b1) begin bad++;
      $display("FAIL idle_clr got=%b/%b/%b want=1/0/1", ifa.cnt_clear, ifa.ro_enable, ifb.cnt_clear); end
  endtask

  task automatic test_all_ones;
    int cyc; bit bok, to; logic [15:0] r; int d0;
    use_tbl = 1'b0; c1 = 12'd100; c2 = 12'd50;
    d0 = done_a;
    run_a(1'b0, 1'b0, cyc, bok, to, r);
    total++; if (to || cyc != A_LEN) begin bad++;
      $display("FAIL ones_latency got=%0d want=%0d", cyc, A_LEN); end
    total++; if (r !== 16'hFFFF) begin bad++;
      $display("FAIL ones_resp got=%h want=FFFF", r); end
    total++; if (!bok) begin bad++;
      $display("FAIL ones_busy got=gap want=continuous"); end
    total++; if (done_a - d0 != 1) begin bad++;
      $display("FAIL ones_done_count got=%0d want=1", done_a - d0); end
  endtask

  task automatic test_all_zeros;
    int cyc = 1; bit prev; logic [7:0] pq [$]; logic [7:0] ep; int perr = 0;
    use_tbl = 1'b0; c1 = 12'd50; c2 = 12'd100;
    @(negedge clock); ifb.start = 1'b1;
    @(negedge clock); ifb.start = 1'b0;
    prev = ifb.ro_enable;
    while (ifb.done !== 1'b1 && cyc < 2000) begin
      if (ifb.ro_enable && !prev) pq.push_back({ifb.select1, ifb.select2});
      prev = ifb.ro_enable;
      @(negedge clock);
      cyc++;
    end
    total++; if (cyc != B_LEN) begin bad++;
      $display("FAIL zeros_latency got=%0d want=%0d", cyc, B_LEN); end
    total++; if (ifb.response !== 16'h0000) begin bad++;
      $display("FAIL zeros_resp got=%h want=0000", ifb.response); end
    total++; if (pq.size() != B_NB) begin bad++;
      $display("FAIL zeros_phases got=%0d want=%0d", pq.size(), B_NB); end
    foreach (pq[i]) begin
      ep = {4'(i), 4'((i + B_OFF) % 16)};
      if (pq[i] !== ep) perr++;
    end
    total++; if (perr != 0) begin bad++;
      $display("FAIL zeros_selects got=%0d_wrong want=0_wrong", perr); end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_wrap_equal;
    int cyc; bit bok, to; logic [15:0] r;
    use_tbl = 1'b0; c1 = 12'd7; c2 = 12'd7;
    run_a(1'b0, 1'b0, cyc, bok, to, r);
    total++; if (to || r !== 16'hFFFF) begin bad++;
      $display("FAIL equal_resp got=%h want=FFFF", r); end
    total++; if (pairs_a.size() != 16 || pairs_a[15] !== 8'hF0) begin bad++;
      $display("FAIL wrap_sel got=%h want=f0", pairs_a.size() == 16 ? pairs_a[15] : 8'hxx); end
  endtask

  task automatic test_ignore_start;
    int cyc; bit bok, to; logic [15:0] r; int d0;
    use_tbl = 1'b0; c1 = 12'd100; c2 = 12'd50;
    d0 = done_a;
    run_a(1'b1, 1'b1, cyc, bok, to, r);
    repeat (10) @(negedge clock);
    total++; if (to || cyc != A_LEN) begin bad++;
      $display("FAIL ignore_latency got=%0d want=%0d", cyc, A_LEN); end
    total++; if (done_a - d0 != 1 || !bok) begin bad++;
      $display("FAIL ignore_done got=%0d busy_ok=%b want=1 busy_ok=1", done_a - d0, bok); end
    total++; if (ifa.busy !== 1'b0 || ifa.response !== 16'hFFFF) begin bad++;
      $display("FAIL ignore_idle got=%b/%h want=0/ffff", ifa.busy, ifa.response); end
  endtask

  task automatic test_reset_mid;
    int n = 0; int d0;
    use_tbl = 1'b0; c1 = 12'd100; c2 = 12'd50;
    pairs_a.delete();
    d0 = done_a;
    @(negedge clock); ifa.start = 1'b1;
    @(negedge clock); ifa.start = 1'b0;
    while (!(pairs_a.size() == 6 && ifa.ro_enable) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    total++; if (n >= 3000) begin bad++;
      $display("FAIL midreset_reach got=timeout want=bit5_measure"); end
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    total++; if (ifa.ro_enable !== 1'b0 || ifa.cnt_clear !== 1'b1 || ifa.busy !== 1'b0) begin bad++;
      $display("FAIL midreset_out got=%b/%b/%b want=0/1/0", ifa.ro_enable, ifa.cnt_clear, ifa.busy); end
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    total++; if (done_a != d0 || ifa.response !== 16'h0000) begin bad++;
      $display("FAIL midreset_nodone got=%0d/%h want=0/0000", done_a - d0, ifa.response); end
  endtask

  task automatic test_random;
    int cyc; bit bok, to; logic [15:0] r, exp; int perr, rerr, d0;
    for (int it = 0; it < 5; it++) begin
      for (int j = 0; j < 16; j++) tbl[j] = 12'($urandom_range(0, 4095));
      for (int j = 0; j < 16; j++)
        if ($urandom_range(0, 3) == 0) tbl[j] = tbl[(j + A_OFF) % 16];
      exp = '0;
      for (int k = 0; k < A_NB; k++) exp[k] = (tbl[k] >= tbl[(k + A_OFF) % 16]);
      use_tbl = 1'b1;
      d0 = done_a;
      run_a(1'b0, 1'b0, cyc, bok, to, r);
      perr = 0; rerr = 0;
      foreach (pairs_a[i]) if (pairs_a[i] !== {4'(i), 4'((i + A_OFF) % 16)}) perr++;
      foreach (runs_a[i]) if (runs_a[i] != A_W) rerr++;
      total++; if (to || r !== exp) begin bad++;
        $display("FAIL rand_resp it=%0d got=%h want=%h", it, r, exp); end
      total++; if (pairs_a.size() != A_NB || perr != 0) begin bad++;
        $display("FAIL rand_sel it=%0d got=%0d_pairs/%0d_wrong want=%0d/0", it, pairs_a.size(), perr, A_NB); end
      total++; if (runs_a.size() != A_NB || rerr != 0) begin bad++;
        $display("FAIL rand_window it=%0d got=%0d_runs/%0d_wrong want=%0d/0", it, runs_a.size(), rerr, A_NB); end
      total++; if (cyc != A_LEN || done_a - d0 != 1) begin bad++;
        $display("FAIL rand_len it=%0d got=%0d/%0d want=%0d/1", it, cyc, done_a - d0, A_LEN); end
    end
    use_tbl = 1'b0;
  endtask

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_wrap_equal();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
